// File: rtl/uart_pkg.sv
// ----------------------------------------------------------------------------
// uart_pkg : shared UART types, divider rounding and sample-point helpers
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    BREAK  = 3'd5
  } uart_state_e;

  localparam int UART_OS_DEFAULT = 16;

  // Clocks per oversampling tick, rounded to nearest.
  function automatic int uart_div(input int clk_hz, input int baud, input int os);
    return (clk_hz + (baud * os) / 2) / (baud * os);
  endfunction

  // Tick index within a bit at which the line is sampled (bit centre).
  function automatic int uart_sample_pt(input int os);
    return os / 2 - 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_rx_if.sv
// ----------------------------------------------------------------------------
// uart_rx_if : valid/ready byte stream from the UART receiver to its consumer
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface uart_rx_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ready;

  modport master (
    output rx_data,
    output rx_valid,
    input  rx_ready
  );

  modport slave (
    input  rx_data,
    input  rx_valid,
    output rx_ready
  );
endinterface

`default_nettype wire

// File: rtl/uart_baud_tick.sv
// ----------------------------------------------------------------------------
// uart_baud_tick : free-running 1-cycle tick every DIV clocks, restartable
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module uart_baud_tick #(
  parameter int DIV = 27
) (
  input  wire logic clk,
  input  wire logic reset_n,
  input  wire logic i_restart,
  output logic      o_tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] r_cnt;
  logic          w_wrap;

  assign w_wrap = (r_cnt == CW'(DIV - 1));
  assign o_tick = w_wrap & ~i_restart;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (i_restart || w_wrap) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/uart_rx.sv
// ----------------------------------------------------------------------------
// uart_rx : oversampling UART receiver, byte out on valid/ready.
//           Define UART_RX_PARITY_EN to add a checked parity bit.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int BAUD       = 115200,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY_ODD = 0
) (
  input  wire logic  clk,
  input  wire logic  reset_n,
  input  wire logic  rxd,
  uart_rx_if.master  rx_if,
  output logic       busy,
  output logic       frame_err,
  output logic       overrun_err,
  output logic       parity_err
);

  localparam int DIV      = uart_div(CLK_HZ, BAUD, OVERSAMPLE);
  localparam int OSW      = $clog2(OVERSAMPLE);
  localparam int SAMPLE_PT = uart_sample_pt(OVERSAMPLE);

  if (OVERSAMPLE < 8 || (OVERSAMPLE % 2) != 0 || DATA_BITS < 5 || DATA_BITS > 8 ||
      PARITY_ODD < 0 || PARITY_ODD > 1 || DIV < 1) begin : g_bad_cfg
    $error("uart_rx: unsupported parameter combination");
  end

  uart_state_e            r_state;
  uart_state_e            w_next;
  logic                   r_sync1;
  logic                   r_rxd_s;
  logic [OSW-1:0]         r_os;
  logic [2:0]             r_bit;
  logic [DATA_BITS-1:0]   r_shift;
  logic [DATA_BITS-1:0]   r_data;
  logic                   r_valid;
  logic                   r_frame_err;
  logic                   r_overrun_err;

  logic                   w_tick;
  logic                   w_sample;
  logic                   w_restart;
  logic                   w_shift;
  logic                   w_stop_sample;
  logic                   w_deliver;
  logic                   w_frame;
  logic                   w_hs;
  logic                   w_last_bit;
`ifdef UART_RX_PARITY_EN
  logic                   w_par_sample;
  logic                   r_par_bad;
  logic                   r_parity_err;
`endif

  // rxd is asynchronous; only r_rxd_s is used downstream.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= 1'b1;
      r_rxd_s <= 1'b1;
    end else begin
      r_sync1 <= rxd;
      r_rxd_s <= r_sync1;
    end
  end

  uart_baud_tick #(
    .DIV (DIV)
  ) u_tick (
    .clk       (clk),
    .reset_n   (reset_n),
    .i_restart (w_restart),
    .o_tick    (w_tick)
  );

  assign w_sample   = w_tick & (r_os == OSW'(SAMPLE_PT));
  assign w_last_bit = (r_bit == 3'(DATA_BITS - 1));

  // FSM: state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // FSM: next state
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:   if (!r_rxd_s) w_next = START;
      START:  if (w_sample) w_next = r_rxd_s ? IDLE : DATA;
      DATA: begin
        if (w_sample && w_last_bit) begin
`ifdef UART_RX_PARITY_EN
          w_next = PARITY;
`else
          w_next = STOP;
`endif
        end
      end
      PARITY: if (w_sample) w_next = STOP;
      // Leave at the stop-bit centre so the next start edge is caught early.
      STOP:   if (w_sample) w_next = r_rxd_s ? IDLE : BREAK;
      BREAK:  if (r_rxd_s) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    w_restart     = (r_state == IDLE) & ~r_rxd_s;
    w_shift       = (r_state == DATA) & w_sample;
    w_stop_sample = (r_state == STOP) & w_sample;
    w_deliver     = w_stop_sample & r_rxd_s;
    w_frame       = w_stop_sample & ~r_rxd_s;
`ifdef UART_RX_PARITY_EN
    w_par_sample  = (r_state == PARITY) & w_sample;
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_os    <= '0;
      r_bit   <= '0;
      r_shift <= '0;
    end else begin
      if (w_restart) begin
        r_os <= '0;
      end else if (w_tick) begin
        r_os <= (r_os == OSW'(OVERSAMPLE - 1)) ? '0 : r_os + 1'b1;
      end

      if (w_restart) begin
        r_bit <= '0;
      end else if (w_shift) begin
        r_bit <= r_bit + 1'b1;
      end

      if (w_shift) begin
        r_shift <= {r_rxd_s, r_shift[DATA_BITS-1:1]};
      end
    end
  end

  assign w_hs = r_valid & rx_if.rx_ready;

  // A delivery coinciding with a handshake replaces the byte without overrun.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_data        <= '0;
      r_valid       <= 1'b0;
      r_frame_err   <= 1'b0;
      r_overrun_err <= 1'b0;
    end else begin
      r_frame_err   <= w_frame;
      r_overrun_err <= 1'b0;
      if (w_deliver) begin
        if (!r_valid || w_hs) begin
          r_data  <= r_shift;
          r_valid <= 1'b1;
        end else begin
          r_overrun_err <= 1'b1;
        end
      end else if (w_hs) begin
        r_valid <= 1'b0;
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_par_bad    <= 1'b0;
      r_parity_err <= 1'b0;
    end else begin
      if (w_restart) begin
        r_par_bad <= 1'b0;
      end else if (w_par_sample) begin
        r_par_bad <= (r_rxd_s != ((^r_shift) ^ (PARITY_ODD != 0)));
      end
      r_parity_err <= w_stop_sample & r_par_bad;
    end
  end

  assign parity_err = r_parity_err;
`else
  assign parity_err = 1'b0;
`endif

  assign rx_if.rx_data  = r_data;
  assign rx_if.rx_valid = r_valid;
  assign busy           = (r_state != IDLE);
  assign frame_err      = r_frame_err;
  assign overrun_err    = r_overrun_err;

endmodule

`default_nettype wire

// File: tb/tb_uart_rx.sv
// ----------------------------------------------------------------------------
// tb_uart_rx : directed self-checking bench for uart_rx at default parameters
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_uart_rx;
  import uart_pkg::*;

  localparam int BIT_CLKS = 432;

  logic clk;
  logic rst_n;
  logic rxd;
  logic busy;
  logic frame_err;
  logic overrun_err;
  logic parity_err;

  int n_tests;
  int n_fail;
  int cyc;
  int hs_cnt;
  int valid_cyc;
  int rise_cyc;
  int frame_cnt;
  int overrun_cnt;
  int parity_cnt;
  logic [7:0] hs_data;
  logic prev_valid;

  uart_rx_if #(.DATA_BITS(8)) u_if ();

  uart_rx dut (
    .clk         (clk),
    .reset_n     (rst_n),
    .rxd         (rxd),
    .rx_if       (u_if),
    .busy        (busy),
    .frame_err   (frame_err),
    .overrun_err (overrun_err),
    .parity_err  (parity_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_valid <= 1'b0;
    end else begin
      if (u_if.rx_valid && u_if.rx_ready) begin
        hs_cnt  <= hs_cnt + 1;
        hs_data <= u_if.rx_data;
      end
      if (u_if.rx_valid) valid_cyc <= valid_cyc + 1;
      if (u_if.rx_valid && !prev_valid) rise_cyc <= cyc;
      prev_valid <= u_if.rx_valid;
      if (frame_err)   frame_cnt   <= frame_cnt + 1;
      if (overrun_err) overrun_cnt <= overrun_cnt + 1;
      if (parity_err)  parity_cnt  <= parity_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_bit(input logic v);
    rxd = v;
    tick(BIT_CLKS);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit(par);
`endif
    drive_bit(stop);
    rxd = 1'b1;
  endtask

  function automatic logic even_par(input logic [7:0] d);
    return ^d;
  endfunction

  initial begin
    int t0;
    int base_hs;
    int base_vc;
    int base_fr;
    int base_ov;
    n_tests = 0; n_fail = 0; cyc = 0;
    hs_cnt = 0; valid_cyc = 0; rise_cyc = 0;
    frame_cnt = 0; overrun_cnt = 0; parity_cnt = 0;
    hs_data = '0; prev_valid = 1'b0;
    rxd = 1'b1;
    u_if.rx_ready = 1'b1;
    rst_n = 1'b0;
    tick(5);
    @(negedge clk);
    check("rst_valid", 32'(u_if.rx_valid), 32'd0);
    check("rst_data",  32'(u_if.rx_data),  32'd0);
    check("rst_busy",  32'(busy),          32'd0);
    check("rst_errs",  {29'd0, frame_err, overrun_err, parity_err}, 32'd0);
    rst_n = 1'b1;
    tick(50);

    // 0xA5, consumer always ready
    base_hs = hs_cnt; base_vc = valid_cyc;
    t0 = cyc;
    send_frame(8'hA5, even_par(8'hA5), 1'b1);
    tick(200);
    check("a5_data",   32'(hs_data), 32'hA5);
    check("a5_hs",     32'(hs_cnt - base_hs), 32'd1);
    check("a5_vcyc",   32'(valid_cyc - base_vc), 32'd1);
    check("a5_latency", 32'((rise_cyc - t0 >= 4000) && (rise_cyc - t0 <= 4200)), 32'd1);

    // false start
    base_hs = hs_cnt;
    rxd = 1'b0;
    tick(50);
    @(negedge clk);
    check("fs_busy_mid", 32'(busy), 32'd1);
    tick(50);
    rxd = 1'b1;
    tick(500);
    @(negedge clk);
    check("fs_busy_end", 32'(busy), 32'd0);
    check("fs_no_byte",  32'(hs_cnt - base_hs), 32'd0);
    check("fs_no_err",   32'(frame_cnt + overrun_cnt + parity_cnt), 32'd0);

    // framing error then break, then recovery
    base_hs = hs_cnt; base_fr = frame_cnt;
    send_frame(8'h3C, even_par(8'h3C), 1'b0);
    rxd = 1'b0;
    tick(2000);
    @(negedge clk);
    check("fe_pulse",    32'(frame_cnt - base_fr), 32'd1);
    check("fe_no_byte",  32'(hs_cnt - base_hs), 32'd0);
    check("fe_brk_busy", 32'(busy), 32'd1);
    rxd = 1'b1;
    tick(2 * BIT_CLKS);
    send_frame(8'h55, even_par(8'h55), 1'b1);
    tick(200);
    check("fe_rec_data", 32'(hs_data), 32'h55);

    // overrun with consumer stalled
    u_if.rx_ready = 1'b0;
    base_ov = overrun_cnt; base_hs = hs_cnt;
    send_frame(8'h11, even_par(8'h11), 1'b1);
    send_frame(8'h22, even_par(8'h22), 1'b1);
    tick(200);
    @(negedge clk);
    check("ov_data",  32'(u_if.rx_data), 32'h11);
    check("ov_valid", 32'(u_if.rx_valid), 32'd1);
    check("ov_pulse", 32'(overrun_cnt - base_ov), 32'd1);
    tick(1);
    u_if.rx_ready = 1'b1;
    tick(1);
    u_if.rx_ready = 1'b0;
    tick(3);
    @(negedge clk);
    check("ov_accept",  32'(hs_data), 32'h11);
    check("ov_hs_once", 32'(hs_cnt - base_hs), 32'd1);
    check("ov_cleared", 32'(u_if.rx_valid), 32'd0);
    u_if.rx_ready = 1'b1;
    tick(BIT_CLKS);

    // reset in the middle of bit 4 of 0xFF
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'b1);
    tick(200);
    rst_n = 1'b0;
    tick(3);
    @(negedge clk);
    check("mr_valid", 32'(u_if.rx_valid), 32'd0);
    check("mr_data",  32'(u_if.rx_data),  32'd0);
    check("mr_busy",  32'(busy),          32'd0);
    rst_n = 1'b1;
    rxd = 1'b1;
    tick(2 * BIT_CLKS);
    base_hs = hs_cnt;
    send_frame(8'h0F, even_par(8'h0F), 1'b1);
    tick(200);
    check("mr_next_data", 32'(hs_data), 32'h0F);
    check("mr_next_hs",   32'(hs_cnt - base_hs), 32'd1);

`ifdef UART_RX_PARITY_EN
    begin
      int base_par;
      base_par = parity_cnt;
      send_frame(8'h07, 1'b0, 1'b1);
      tick(200);
      check("par_pulse", 32'(parity_cnt - base_par), 32'd1);
      check("par_data",  32'(hs_data), 32'h07);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
